// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - UART byte-stream command decoder driving a register read/write port
module uart_cmd_ctrl #(
  parameter int RD_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_data_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_block_timeout,
  output logic [6:0] reg_addr,
  output logic       reg_wr_en,
  output logic [7:0] reg_wdata,
  output logic       reg_rd_en,
  input  logic [7:0] reg_rdata,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  output logic       busy,
  output logic       err_overrun
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_DATA,
    ST_RD_LEN,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_RD_SEND
  } state_t;

  // Last wait-counter value before reg_rdata is valid.
  localparam logic [1:0] LAT_LAST = 2'(RD_LATENCY - 1);

  state_t     r_state, w_state_nxt;
  logic [6:0] r_addr, w_addr_nxt;
  logic [7:0] r_wdata, w_wdata_nxt;
  logic       r_wr_en, w_wr_en_nxt;
  logic       r_rd_en, w_rd_en_nxt;
  logic       r_tx_valid, w_tx_valid_nxt;
  logic [7:0] r_tx_data, w_tx_data_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_err, w_err_nxt;
  logic [8:0] r_remain, w_remain_nxt;
  logic [1:0] r_wait_cnt, w_wait_cnt_nxt;

  // State and every output held in flops; async clear to the idle picture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_addr     <= 7'd0;
      r_wdata    <= 8'd0;
      r_wr_en    <= 1'b0;
      r_rd_en    <= 1'b0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'd0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_remain   <= 9'd0;
      r_wait_cnt <= 2'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_addr     <= w_addr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_wr_en    <= w_wr_en_nxt;
      r_rd_en    <= w_rd_en_nxt;
      r_tx_valid <= w_tx_valid_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_busy     <= w_busy_nxt;
      r_err      <= w_err_nxt;
      r_remain   <= w_remain_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  // Next-state and next-output decode; strobes default low so they last one cycle.
  always_comb begin
    w_state_nxt    = r_state;
    w_addr_nxt     = r_addr;
    w_wdata_nxt    = r_wdata;
    w_wr_en_nxt    = 1'b0;
    w_rd_en_nxt    = 1'b0;
    w_tx_valid_nxt = r_tx_valid;
    w_tx_data_nxt  = r_tx_data;
    w_err_nxt      = 1'b0;
    w_remain_nxt   = r_remain;
    w_wait_cnt_nxt = r_wait_cnt;

    // The address advances in the cycle after the write strobe, so the
    // strobe itself always presents the address the data belongs to.
    if (r_wr_en) begin
      w_addr_nxt = r_addr + 7'd1;
    end

    case (r_state)
      ST_IDLE: begin
        if (rx_data_valid) begin
          w_addr_nxt  = rx_data[6:0];
          w_state_nxt = rx_data[7] ? ST_WR_DATA : ST_RD_LEN;
        end
      end
      ST_WR_DATA: begin
        if (rx_data_valid) begin
          w_wr_en_nxt = 1'b1;
          w_wdata_nxt = rx_data;
        end
        if (rx_block_timeout) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RD_LEN: begin
        // A timeout beats a coincident length byte: no read is started.
        if (rx_block_timeout) begin
          w_state_nxt = ST_IDLE;
        end else if (rx_data_valid) begin
          w_remain_nxt = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
          w_rd_en_nxt  = 1'b1;
          w_state_nxt  = ST_RD_ISSUE;
        end
      end
      ST_RD_ISSUE: begin
        // The read strobe was raised on entry, so it is high exactly here.
        w_wait_cnt_nxt = 2'd0;
        w_state_nxt    = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (r_wait_cnt == LAT_LAST) begin
          w_tx_data_nxt  = reg_rdata;
          w_tx_valid_nxt = 1'b1;
          w_state_nxt    = ST_RD_SEND;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + 2'd1;
        end
      end
      ST_RD_SEND: begin
        if (tx_ready) begin
          w_tx_valid_nxt = 1'b0;
          w_addr_nxt     = r_addr + 7'd1;
          w_remain_nxt   = r_remain - 9'd1;
          if (r_remain == 9'd1) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_rd_en_nxt = 1'b1;
            w_state_nxt = ST_RD_ISSUE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Bytes arriving during a read burst cannot be parsed; drop and flag them.
    if (rx_data_valid &&
        (r_state inside {ST_RD_ISSUE, ST_RD_WAIT, ST_RD_SEND})) begin
      w_err_nxt = 1'b1;
    end

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  assign reg_addr    = r_addr;
  assign reg_wr_en   = r_wr_en;
  assign reg_wdata   = r_wdata;
  assign reg_rd_en   = r_rd_en;
  assign tx_valid    = r_tx_valid;
  assign tx_data     = r_tx_data;
  assign busy        = r_busy;
  assign err_overrun = r_err;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb/tb_uart_cmd_ctrl.sv - scoreboard bench for uart_cmd_ctrl
module tb_uart_cmd_ctrl;
  localparam int LAT = 1;

  typedef struct {
    int         cyc;
    logic [6:0] addr;
    logic [7:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       rx_data_valid = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       rx_block_timeout = 1'b0;
  logic [6:0] reg_addr;
  logic       reg_wr_en;
  logic [7:0] reg_wdata;
  logic       reg_rd_en;
  logic [7:0] reg_rdata;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready = 1'b0;
  logic       busy;
  logic       err_overrun;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int ready_mode = 0;
  logic [6:0] m_addr;

  logic [7:0] rom [0:127];
  logic [7:0] pipe [0:3];

  wr_t        exp_wr[$];
  logic [6:0] exp_rd[$];
  logic [7:0] exp_tx[$];
  int         exp_err[$];

  uart_cmd_ctrl #(.RD_LATENCY(LAT)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .rx_data_valid    (rx_data_valid),
    .rx_data          (rx_data),
    .rx_block_timeout (rx_block_timeout),
    .reg_addr         (reg_addr),
    .reg_wr_en        (reg_wr_en),
    .reg_wdata        (reg_wdata),
    .reg_rd_en        (reg_rd_en),
    .reg_rdata        (reg_rdata),
    .tx_valid         (tx_valid),
    .tx_data          (tx_data),
    .tx_ready         (tx_ready),
    .busy             (busy),
    .err_overrun      (err_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register file: data for a read appears exactly LAT cycles after the strobe, noise otherwise.
  always @(posedge clk) begin
    pipe[0] <= reg_rd_en ? rom[reg_addr] : 8'($urandom);
    for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
  end
  assign reg_rdata = pipe[LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexp(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
  endtask

  // Transmitter back-pressure.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       tx_ready = 1'($urandom_range(0, 1));
        1:       tx_ready = 1'b1;
        default: tx_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops expectations whenever the DUT presents an output.
  initial begin
    logic       hold;
    logic [7:0] hold_data;
    logic       prev_wr, prev_rd, prev_err;
    wr_t        e;
    hold = 1'b0; hold_data = 8'd0;
    prev_wr = 1'b0; prev_rd = 1'b0; prev_err = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 1'b0; prev_wr = 1'b0; prev_rd = 1'b0; prev_err = 1'b0;
      end else begin
        if (hold) begin
          chk("tx_hold_valid", 32'(tx_valid), 32'd1);
          chk("tx_hold_data", 32'(tx_data), 32'(hold_data));
        end
        hold = tx_valid && !tx_ready;
        hold_data = tx_data;
        if (tx_valid && tx_ready) begin
          if (exp_tx.size() == 0) unexp("tx_handshake");
          else chk("tx_data", 32'(tx_data), 32'(exp_tx.pop_front()));
        end
        if (reg_wr_en) begin
          if (prev_wr) unexp("wr_en_2cycles");
          if (exp_wr.size() == 0) unexp("reg_write");
          else begin
            e = exp_wr.pop_front();
            chk("wr_addr", 32'(reg_addr), 32'(e.addr));
            chk("wr_data", 32'(reg_wdata), 32'(e.data));
            chk("wr_cycle", 32'(cyc), 32'(e.cyc));
          end
        end
        if (reg_rd_en) begin
          if (prev_rd) unexp("rd_en_2cycles");
          if (exp_rd.size() == 0) unexp("reg_read");
          else chk("rd_addr", 32'(reg_addr), 32'(exp_rd.pop_front()));
        end
        if (err_overrun) begin
          if (prev_err) unexp("err_2cycles");
          if (exp_err.size() == 0) unexp("err_overrun");
          else chk("err_cycle", 32'(cyc), 32'(exp_err.pop_front()));
        end
        prev_wr = reg_wr_en;
        prev_rd = reg_rd_en;
        prev_err = err_overrun;
      end
    end
  end

  task automatic drive(input logic [7:0] b, input logic to, output int t);
    @(posedge clk);
    #1;
    rx_data = b;
    rx_data_valid = 1'b1;
    rx_block_timeout = to;
    t = cyc;
  endtask

  task automatic release_rx();
    @(posedge clk);
    #1;
    rx_data_valid = 1'b0;
    rx_block_timeout = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic pulse_to();
    @(posedge clk);
    #1;
    rx_block_timeout = 1'b1;
    @(posedge clk);
    #1;
    rx_block_timeout = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic cmd_write(input logic [6:0] a);
    int t;
    drive({1'b1, a}, 1'b0, t);
    release_rx();
    m_addr = a;
  endtask

  // Model: each data byte writes the current address one cycle after its pulse, then the address steps mod 128.
  task automatic wr_data(input logic [7:0] d, input logic to);
    int t;
    drive(d, to, t);
    exp_wr.push_back('{t + 1, m_addr, d});
    m_addr = m_addr + 7'd1;
    release_rx();
  endtask

  // Model: count c (0 means 256) reads at consecutive addresses mod 128, each returned on tx.
  task automatic cmd_read(input logic [6:0] a, input logic [7:0] c);
    int t;
    int n;
    logic [6:0] ra;
    drive({1'b0, a}, 1'b0, t);
    release_rx();
    drive(c, 1'b0, t);
    n = (c == 8'd0) ? 256 : int'(c);
    ra = a;
    for (int i = 0; i < n; i++) begin
      exp_rd.push_back(ra);
      exp_tx.push_back(rom[ra]);
      ra = ra + 7'd1;
    end
    release_rx();
  endtask

  task automatic wait_idle(input int limit);
    int k;
    k = 0;
    while (busy && k < limit) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic wait_tx(input int limit);
    int k;
    k = 0;
    while (!tx_valid && k < limit) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("tx_valid_seen", 32'(tx_valid), 32'd1);
  endtask

  initial begin
    int t;
    int held;
    int n;
    logic comb;

    for (int i = 0; i < 128; i++) rom[i] = 8'($urandom);
    #1 rst_n = 1'b0;
    #2;
    chk("reset_outputs", 32'({reg_addr, reg_wr_en, reg_wdata, reg_rd_en, tx_valid, tx_data, busy, err_overrun}), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Writes with increment, then busy drops after timeout.
    cmd_write(7'h05);
    wr_data(8'hAA, 1'b0);
    wr_data(8'hBB, 1'b0);
    pulse_to();
    wait_idle(10);

    // Address wrap on writes.
    cmd_write(7'h7F);
    wr_data(8'h11, 1'b0);
    wr_data(8'h22, 1'b0);
    pulse_to();
    wait_idle(10);

    // Data byte together with timeout: write happens, then idle.
    cmd_write(7'h0A);
    wr_data(8'h77, 1'b1);
    wait_idle(10);

    // Length byte together with timeout: no read.
    drive(8'h33, 1'b0, t);
    release_rx();
    drive(8'h05, 1'b1, t);
    release_rx();
    wait_idle(10);

    // Timeout while idle does nothing.
    pulse_to();
    chk("idle_timeout_busy", 32'(busy), 32'd0);

    // Three reads with the transmitter always ready.
    ready_mode = 1;
    cmd_read(7'h10, 8'd3);
    wait_idle(100);

    // Back-pressure: tx held stable for 10 cycles, then accepted.
    ready_mode = 2;
    cmd_read(7'h20, 8'd1);
    wait_tx(50);
    held = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (tx_valid && tx_data == rom[7'h20] && busy) held++;
    end
    chk("hold_cycles", 32'(held), 32'd10);
    ready_mode = 1;
    wait_idle(20);

    // Count 0 means 256 reads, wrapping the address.
    ready_mode = 0;
    cmd_read(7'h7A, 8'd0);
    wait_idle(5000);

    // Byte during RD_SEND flags overrun; a timeout there is ignored.
    ready_mode = 2;
    cmd_read(7'h40, 8'd3);
    wait_tx(50);
    drive(8'h99, 1'b0, t);
    exp_err.push_back(t + 1);
    release_rx();
    pulse_to();
    chk("busy_after_ignored_to", 32'(busy), 32'd1);
    ready_mode = 0;
    wait_idle(200);

    // Randomised command blocks.
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        cmd_write(7'($urandom));
        n = $urandom_range(1, 4);
        comb = 1'($urandom_range(0, 1));
        for (int j = 0; j < n; j++) wr_data(8'($urandom), (j == n - 1) && comb);
        if (!comb) pulse_to();
        wait_idle(20);
      end else begin
        cmd_read(7'($urandom), 8'($urandom_range(1, 8)));
        wait_idle(500);
      end
    end

    // Reset mid-burst abandons the read; next bytes parse as a fresh command.
    cmd_read(7'h70, 8'd40);
    repeat (15) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midburst_reset_outputs", 32'({reg_addr, reg_wr_en, reg_wdata, reg_rd_en, tx_valid, tx_data, busy, err_overrun}), 32'd0);
    exp_rd.delete();
    exp_tx.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    cmd_write(7'h01);
    wr_data(8'h55, 1'b0);
    pulse_to();
    wait_idle(10);

    repeat (10) @(posedge clk);
    chk("left_wr", 32'(exp_wr.size()), 32'd0);
    chk("left_rd", 32'(exp_rd.size()), 32'd0);
    chk("left_tx", 32'(exp_tx.size()), 32'd0);
    chk("left_err", 32'(exp_err.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/uart_cmd_ctrl.md
UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 The block SHALL have parameter RD_LATENCY, default 1, meaning the clk cycles from reg_rd_en high to reg_rdata valid (legal range 1..4).
REQ-002 The block SHALL have port clk  input  1  system clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port rx_data_valid  input  1  one-cycle pulse; rx_data holds a received byte.
REQ-005 The block SHALL have port rx_data  input  8  received byte.
REQ-006 The block SHALL have port rx_block_timeout  input  1  one-cycle pulse marking the end of a UART block.
REQ-007 The block SHALL have port reg_addr  output  7  register address.
REQ-008 The block SHALL have port reg_wr_en  output  1  one-cycle register write strobe.
REQ-009 The block SHALL have port reg_wdata  output  8  register write data.
REQ-010 The block SHALL have port reg_rd_en  output  1  one-cycle register read strobe.
REQ-011 The block SHALL have port reg_rdata  input  8  register read data, valid RD_LATENCY cycles after reg_rd_en.
REQ-012 The block SHALL have port tx_valid  output  1  byte offered to the UART transmitter.
REQ-013 The block SHALL have port tx_data  output  8  byte to transmit.
REQ-014 The block SHALL have port tx_ready  input  1  transmitter accepts tx_data when tx_valid and tx_ready are both high.
REQ-015 The block SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-016 The block SHALL have port err_overrun  output  1  one-cycle pulse when an rx byte is dropped.

Function
REQ-017 FSM states SHALL be IDLE, WR_DATA, RD_LEN, RD_ISSUE, RD_WAIT and RD_SEND.
REQ-018 IDLE, rx_data_valid: latch reg_addr = rx_data[6:0]; rx_data[7]=1 -> WR_DATA; rx_data[7]=0 -> RD_LEN.
REQ-019 WR_DATA, rx_data_valid: next cycle reg_wr_en=1, reg_wdata=byte, reg_addr=current address; the cycle after, address increments mod 128 (127 -> 0).
REQ-020 WR_DATA, rx_block_timeout -> IDLE; the write count is unbounded.
REQ-021 RD_LEN, rx_data_valid: 9-bit remaining count = byte, with 0 meaning 256 -> RD_ISSUE; rx_block_timeout -> IDLE with no read issued.
REQ-022 RD_ISSUE: reg_rd_en high exactly 1 cycle at reg_addr -> RD_WAIT.
REQ-023 RD_WAIT: wait RD_LATENCY cycles, capture reg_rdata into tx_data, set tx_valid=1 -> RD_SEND.
REQ-024 RD_SEND: hold tx_valid and tx_data stable until tx_ready; on handshake drop tx_valid, increment address mod 128, decrement remaining; remaining 0 -> IDLE, else RD_ISSUE.
REQ-025 rx_data_valid in RD_ISSUE, RD_WAIT or RD_SEND: discard the byte, pulse err_overrun 1 cycle, keep the state.
REQ-026 rx_block_timeout in RD_ISSUE, RD_WAIT or RD_SEND: ignore; the read burst completes.
REQ-027 rx_data_valid and rx_block_timeout in the same cycle in WR_DATA: perform the write, then go to IDLE.
REQ-028 rx_data_valid and rx_block_timeout in the same cycle in RD_LEN: timeout wins -> IDLE, no read.
REQ-029 rx_block_timeout in IDLE: no effect.
REQ-030 All outputs SHALL be registered; reg_wr_en, reg_rd_en and err_overrun are never high for 2 consecutive cycles.

Reset
REQ-031 rst_n low SHALL immediately force state IDLE, and these outputs to 0: reg_addr, reg_wdata, tx_data, reg_wr_en, reg_rd_en, tx_valid, busy, err_overrun; the remaining count also resets to 0.
REQ-032 Reset mid-burst SHALL abandon the operation; the first rx byte after release is parsed as a command.

Verification
REQ-033 Bytes 0x85,0xAA,0xBB, then timeout -> writes (0x05,0xAA),(0x06,0xBB), each 1 cycle after its rx pulse; busy=0 after timeout.
REQ-034 Bytes 0xFF,0x11,0x22 -> writes (0x7F,0x11),(0x00,0x22), showing address wrap.
REQ-035 Bytes 0x10,0x03, tx_ready=1, RD_LATENCY=1 -> reads at 0x10,0x11,0x12; three tx handshakes with the matching reg_rdata; then IDLE.
REQ-036 Read 0x20 count 0x01, tx_ready held 0 for 10 cycles -> tx_valid and tx_data stable for 10 cycles; accepted when tx_ready rises.
REQ-037 Count byte 0x00 -> exactly 256 reads; address wraps 0x7F -> 0x00.
REQ-038 rx byte during RD_SEND -> err_overrun 1-cycle pulse, burst unaffected; rst_n low mid-burst -> all outputs 0, next 0x81,0x55 writes (0x01,0x55).
